// File: rtl/score_round_controller.sv
// Runs one timed play round for a selected player, then holds a {PlayerID, Score}
// report request for REQ_HOLD cycles and enforces a GAP-cycle quiet period.
module score_round_controller #(
  parameter int ROUND_TICKS = 10,
  parameter int REQ_HOLD    = 20,
  parameter int GAP         = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       StartRound,
  input  logic       AbortRound,
  input  logic [1:0] PlayerSel,
  input  logic       HitPulse,
  input  logic       TimeTick,
  output logic       ScoreReq,
  output logic [1:0] PlayerID,
  output logic [4:0] Score,
  output logic       RoundActive,
  output logic [3:0] TimeLeft,
  output logic       Busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PLAY     = 2'd1,
    S_REPORT   = 2'd2,
    S_COOLDOWN = 2'd3
  } state_t;

  localparam logic [3:0] ROUND_LOAD = 4'(ROUND_TICKS);
  localparam logic [5:0] HOLD_LOAD  = 6'(REQ_HOLD - 1);
  localparam logic [3:0] GAP_LOAD   = 4'(GAP - 1);

  state_t     state_q, state_d;
  logic       score_req_q, score_req_d;
  logic [1:0] player_id_q, player_id_d;
  logic [4:0] score_q, score_d;
  logic [3:0] time_left_q, time_left_d;
  logic [4:0] hit_count_q, hit_count_d;
  logic [5:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;

  // Hit count as it stands after this cycle's HitPulse, saturating at 31.
  logic [4:0] hit_count_upd;
  logic       final_tick;

  always_comb begin
    hit_count_upd = hit_count_q;
    if (HitPulse && (hit_count_q != 5'd31)) begin
      hit_count_upd = hit_count_q + 5'd1;
    end
    final_tick = TimeTick && (time_left_q == 4'd1);
  end

  always_comb begin
    state_d     = state_q;
    score_req_d = score_req_q;
    player_id_d = player_id_q;
    score_d     = score_q;
    time_left_d = time_left_q;
    hit_count_d = hit_count_q;
    hold_cnt_d  = hold_cnt_q;
    gap_cnt_d   = gap_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (StartRound) begin
          player_id_d = PlayerSel;
          hit_count_d = 5'd0;
          time_left_d = ROUND_LOAD;
          state_d     = S_PLAY;
        end
      end

      S_PLAY: begin
        // Abort wins over a hit or tick landing in the same cycle.
        if (AbortRound) begin
          hit_count_d = 5'd0;
          time_left_d = 4'd0;
          state_d     = S_IDLE;
        end else if (final_tick) begin
          hit_count_d = hit_count_upd;
          score_d     = hit_count_upd;
          time_left_d = 4'd0;
          score_req_d = 1'b1;
          hold_cnt_d  = HOLD_LOAD;
          state_d     = S_REPORT;
        end else begin
          hit_count_d = hit_count_upd;
          if (TimeTick && (time_left_q > 4'd1)) begin
            time_left_d = time_left_q - 4'd1;
          end
        end
      end

      S_REPORT: begin
        if (hold_cnt_q == 6'd0) begin
          score_req_d = 1'b0;
          gap_cnt_d   = GAP_LOAD;
          state_d     = S_COOLDOWN;
        end else begin
          hold_cnt_d = hold_cnt_q - 6'd1;
        end
      end

      S_COOLDOWN: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        score_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      score_req_q <= 1'b0;
      player_id_q <= 2'd0;
      score_q     <= 5'd0;
      time_left_q <= 4'd0;
      hit_count_q <= 5'd0;
      hold_cnt_q  <= 6'd0;
      gap_cnt_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      score_req_q <= score_req_d;
      player_id_q <= player_id_d;
      score_q     <= score_d;
      time_left_q <= time_left_d;
      hit_count_q <= hit_count_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign ScoreReq    = score_req_q;
  assign PlayerID    = player_id_q;
  assign Score       = score_q;
  assign TimeLeft    = time_left_q;
  assign RoundActive = (state_q == S_PLAY);
  assign Busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_score_round_controller.sv
// Bench for score_round_controller: a round-level model queues expected reports,
// and a negedge monitor checks each report's contents, timing, hold and gap lengths.
module tb_score_round_controller;

  localparam int ROUND_TICKS = 3;
  localparam int REQ_HOLD    = 20;
  localparam int GAP         = 4;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       StartRound = 1'b0;
  logic       AbortRound = 1'b0;
  logic [1:0] PlayerSel = 2'd0;
  logic       HitPulse = 1'b0;
  logic       TimeTick = 1'b0;
  logic       ScoreReq;
  logic [1:0] PlayerID;
  logic [4:0] Score;
  logic       RoundActive;
  logic [3:0] TimeLeft;
  logic       Busy;

  score_round_controller #(
    .ROUND_TICKS(ROUND_TICKS),
    .REQ_HOLD(REQ_HOLD),
    .GAP(GAP)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .StartRound(StartRound),
    .AbortRound(AbortRound),
    .PlayerSel(PlayerSel),
    .HitPulse(HitPulse),
    .TimeTick(TimeTick),
    .ScoreReq(ScoreReq),
    .PlayerID(PlayerID),
    .Score(Score),
    .RoundActive(RoundActive),
    .TimeLeft(TimeLeft),
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int pid;
    int score;
    int at;
  } exp_t;
  exp_t exp_q[$];

  // Round-level model: who is playing, hits and ticks seen, last reported score.
  int m_pid = 0;
  int m_hits = 0;
  int m_ticks = 0;
  int last_score = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic next();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_in(input bit st, input bit [1:0] sel, input bit hit, input bit tick,
                        input bit ab);
    StartRound = st;
    PlayerSel  = sel;
    HitPulse   = hit;
    TimeTick   = tick;
    AbortRound = ab;
  endtask

  task automatic start_round(input bit [1:0] sel);
    next();
    chk("start_idle_busy", int'(Busy), 0);
    set_in(1'b1, sel, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
    m_pid   = int'(sel);
    m_hits  = 0;
    m_ticks = 0;
  endtask

  task automatic play_step(input bit hit, input bit tick, input bit ab, input bit junk,
                           output bit done);
    next();
    chk("play_active", int'(RoundActive), 1);
    chk("play_timeleft", int'(TimeLeft), ROUND_TICKS - m_ticks);
    chk("play_pid", int'(PlayerID), m_pid);
    chk("play_req", int'(ScoreReq), 0);
    chk("play_score", int'(Score), last_score);
    set_in(junk, 2'd3, hit, tick, ab);
    done = 1'b0;
    if (ab) begin
      done = 1'b1;
    end else begin
      if (hit) m_hits++;
      if (tick) m_ticks++;
      if (m_ticks == ROUND_TICKS) begin
        last_score = (m_hits > 31) ? 31 : m_hits;
        exp_q.push_back('{m_pid, last_score, cyc + 1});
        done = 1'b1;
      end
    end
  endtask

  task automatic post_abort();
    next();
    chk("abort_busy", int'(Busy), 0);
    chk("abort_active", int'(RoundActive), 0);
    chk("abort_timeleft", int'(TimeLeft), 0);
    chk("abort_score", int'(Score), last_score);
    chk("abort_req", int'(ScoreReq), 0);
    set_in(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic report_wait(input bit junk);
    for (int i = 1; i <= REQ_HOLD + GAP; i++) begin
      next();
      chk("rep_busy", int'(Busy), 1);
      chk("rep_req", int'(ScoreReq), (i <= REQ_HOLD) ? 1 : 0);
      chk("rep_pid", int'(PlayerID), m_pid);
      set_in(junk & 1'($urandom_range(1)), 2'd3, 1'($urandom_range(1)),
             1'($urandom_range(1)), 1'($urandom_range(1)));
    end
  endtask

  task automatic hits_then_ticks(input bit [1:0] sel, input int nhits, input bit junk);
    bit done;
    start_round(sel);
    for (int i = 0; i < nhits; i++) play_step(1'b1, 1'b0, 1'b0, junk, done);
    done = 1'b0;
    while (!done) play_step(1'b0, 1'b1, 1'b0, junk, done);
    report_wait(junk);
  endtask

  task automatic run_round(input bit [1:0] sel, input int hp, input int tp, input int ap,
                           input bit junk);
    bit done;
    bit hit;
    bit tick;
    bit ab;
    int steps;
    start_round(sel);
    done  = 1'b0;
    ab    = 1'b0;
    steps = 0;
    while (!done) begin
      hit  = int'($urandom_range(99)) < hp;
      tick = (int'($urandom_range(99)) < tp) || (steps >= 200);
      ab   = int'($urandom_range(99)) < ap;
      play_step(hit, tick, ab, junk, done);
      steps++;
    end
    if (ab) post_abort();
    else report_wait(junk);
  endtask

  // Monitor: pops an expectation on each ScoreReq rise, then checks stability,
  // the hold length and the cooldown length.
  int   ph = 0;
  int   hold_len = 0;
  int   gap_len = 0;
  bit   rst_pending = 1'b0;
  exp_t cur;

  always @(negedge Clk) begin
    if (rst_pending) begin
      ph = 0;
      rst_pending = 1'b0;
    end else begin
      case (ph)
        0: if (ScoreReq) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_report", int'(ScoreReq), 0);
          end else begin
            cur = exp_q.pop_front();
            $display("report: player %0d score %0d at cycle %0d (expected player %0d score %0d cycle %0d)",
                     PlayerID, Score, cyc, cur.pid, cur.score, cur.at);
            chk("report_pid", int'(PlayerID), cur.pid);
            chk("report_score", int'(Score), cur.score);
            chk("report_cycle", cyc, cur.at);
            hold_len = 1;
            ph = 1;
          end
        end
        1: if (ScoreReq) begin
          hold_len++;
          chk("hold_pid", int'(PlayerID), cur.pid);
          chk("hold_score", int'(Score), cur.score);
        end else begin
          chk("hold_len", hold_len, REQ_HOLD);
          chk("gap_busy", int'(Busy), 1);
          gap_len = 1;
          ph = 2;
        end
        default: if (ScoreReq) begin
          chk("gap_req", int'(ScoreReq), 0);
          ph = 0;
        end else if (Busy) begin
          gap_len++;
        end else begin
          chk("gap_len", gap_len, GAP);
          ph = 0;
        end
      endcase
    end
    if (Rst) rst_pending = 1'b1;
  end

  initial begin
    bit done;
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b0;
    chk("reset_req", int'(ScoreReq), 0);
    chk("reset_pid", int'(PlayerID), 0);
    chk("reset_score", int'(Score), 0);
    chk("reset_active", int'(RoundActive), 0);
    chk("reset_timeleft", int'(TimeLeft), 0);
    chk("reset_busy", int'(Busy), 0);

    // Normal round, then saturation.
    hits_then_ticks(2'd2, 5, 1'b0);
    hits_then_ticks(2'd1, 40, 1'b0);

    // Seventh hit coincides with the final tick.
    start_round(2'd0);
    for (int i = 0; i < 6; i++) play_step(1'b1, 1'b0, 1'b0, 1'b0, done);
    play_step(1'b0, 1'b1, 1'b0, 1'b0, done);
    play_step(1'b0, 1'b1, 1'b0, 1'b0, done);
    play_step(1'b1, 1'b1, 1'b0, 1'b0, done);
    report_wait(1'b0);

    // Abort coincident with a hit and a tick.
    start_round(2'd1);
    for (int i = 0; i < 4; i++) play_step(1'b1, 1'b0, 1'b0, 1'b0, done);
    play_step(1'b1, 1'b1, 1'b1, 1'b0, done);
    post_abort();

    // Starts with PlayerSel=3 throughout PLAY, REPORT and COOLDOWN are ignored.
    hits_then_ticks(2'd1, 6, 1'b1);

    // Reset on the 10th ScoreReq cycle.
    start_round(2'd2);
    for (int i = 0; i < 3; i++) play_step(1'b1, 1'b0, 1'b0, 1'b0, done);
    done = 1'b0;
    while (!done) play_step(1'b0, 1'b1, 1'b0, 1'b0, done);
    for (int i = 0; i < 9; i++) begin
      next();
      set_in(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    end
    next();
    chk("prerst_req", int'(ScoreReq), 1);
    Rst = 1'b1;
    next();
    Rst = 1'b0;
    chk("rst_req", int'(ScoreReq), 0);
    chk("rst_score", int'(Score), 0);
    chk("rst_pid", int'(PlayerID), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_timeleft", int'(TimeLeft), 0);
    m_pid = 0;
    last_score = 0;

    // Back-to-back reports for player 0.
    hits_then_ticks(2'd0, 12, 1'b0);
    hits_then_ticks(2'd0, 9, 1'b0);

    // Randomized rounds.
    for (int r = 0; r < 25; r++) begin
      run_round(2'($urandom_range(3)), int'($urandom_range(100)), int'($urandom_range(50, 5)),
                ($urandom_range(3) == 0) ? 4 : 0, 1'($urandom_range(1)));
    end

    repeat (5) next();
    chk("pending_reports", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
